// File: rtl/cache_line_mem.sv
`default_nettype none
// ============================================================================
// cache_line_mem : line-granular memory stage with fixed access latency,
//                  one word per cycle through a single-port synchronous RAM.
// Revision: 1.0
// ============================================================================
module cache_line_mem #(
    parameter int ADDR_W          = 32,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_LINE  = 4,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] req_wdata,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [WORD_W*WORDS_PER_LINE-1:0] resp_rdata,
    output logic                             busy
);

    localparam int OFF_W   = $clog2(WORD_W / 8);
    localparam int BEAT_W  = $clog2(WORDS_PER_LINE);
    localparam int MADDR_W = $clog2(MEM_DEPTH_WORDS);
    localparam int LIDX_W  = MADDR_W - BEAT_W;
    localparam int LAT_W   = $clog2(MEM_LATENCY + 1);

    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_XFER  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LAT_W-1:0]    lat_cnt;
    logic [BEAT_W-1:0]   beat;
    logic                out_of_reset;
    logic                req_we_q;
    logic [LIDX_W-1:0]   line_idx;
    logic [WORD_W-1:0]   req_word [WORDS_PER_LINE];
    logic [WORD_W-1:0]   line_buf [WORDS_PER_LINE];
    logic [WORD_W-1:0]   mem      [MEM_DEPTH_WORDS];
    logic [WORD_W-1:0]   rd_data;
    logic                rd_valid;
    logic [BEAT_W-1:0]   rd_beat;
    logic                accept;
    logic [MADDR_W-1:0]  mem_addr;
    logic                unused_addr;

    // Ready is held low until the first edge after reset release.
    assign req_ready  = (state == S_IDLE) && out_of_reset;
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign accept     = req_valid && req_ready;

    // Line index sits above the byte and word offsets; upper bits wrap away.
    assign mem_addr    = {line_idx, beat};
    assign unused_addr = ^req_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid && out_of_reset) state_nxt = S_WAIT;
            S_WAIT:  if (lat_cnt == LAT_LAST)       state_nxt = S_XFER;
            S_XFER:  if (beat == BEAT_LAST)         state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_RESP;
            S_RESP:  if (resp_ready)                state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_cnt      <= '0;
            beat         <= '0;
            out_of_reset <= 1'b0;
            req_we_q     <= 1'b0;
            line_idx     <= '0;
            rd_valid     <= 1'b0;
            rd_beat      <= '0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                req_word[i] <= '0;
                line_buf[i] <= '0;
            end
        end else begin
            out_of_reset <= 1'b1;
            // Read data returns one edge after the access; the DRAIN edge catches the last word.
            rd_valid     <= (state == S_XFER) && !req_we_q;
            rd_beat      <= beat;
            if (rd_valid) begin
                line_buf[rd_beat] <= rd_data;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_we_q <= req_we;
                        line_idx <= req_addr[OFF_W+BEAT_W +: LIDX_W];
                        lat_cnt  <= '0;
                        for (int i = 0; i < WORDS_PER_LINE; i++) begin
                            req_word[i] <= req_wdata[i*WORD_W +: WORD_W];
                            if (req_we) begin
                                line_buf[i] <= req_wdata[i*WORD_W +: WORD_W];
                            end
                        end
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    beat    <= '0;
                end
                S_XFER: begin
                    beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && (state == S_XFER)) begin
            if (req_we_q) begin
                mem[mem_addr] <= req_word[beat];
            end else begin
                rd_data <= mem[mem_addr];
            end
        end
    end

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_pack
        assign resp_rdata[gi*WORD_W +: WORD_W] = line_buf[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_mem.sv
`default_nettype none
// Directed testbench for cache_line_mem: default instance plus a
// MEM_LATENCY=1 / WORDS_PER_LINE=8 instance.
module tb_cache_line_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         a_req_valid, a_req_ready, a_req_we;
    logic [31:0]  a_req_addr;
    logic [127:0] a_req_wdata;
    logic         a_resp_valid, a_resp_ready;
    logic [127:0] a_resp_rdata;
    logic         a_busy;

    logic         b_req_valid, b_req_ready, b_req_we;
    logic [31:0]  b_req_addr;
    logic [255:0] b_req_wdata;
    logic         b_resp_valid, b_resp_ready;
    logic [255:0] b_resp_rdata;
    logic         b_busy;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] L1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] LA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] LB = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

    cache_line_mem u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .busy(a_busy)
    );

    cache_line_mem #(
        .ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(8),
        .MEM_DEPTH_WORDS(1024), .MEM_LATENCY(1)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .busy(b_busy)
    );

    // Full transaction on instance A with resp_ready held high.
    task automatic a_txn(input logic we, input logic [31:0] addr, input logic [127:0] wdata,
                         output logic [127:0] rdata, output int lat);
        int n;
        a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        a_req_valid = 1'b1; a_resp_ready = 1'b1;
        n = 0;
        while (!a_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++; $display("FAIL a_accept: req_ready=%b required 1", a_req_ready);
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 0;
        while (!a_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = a_resp_rdata;
        @(posedge clk); #1;
    endtask

    task automatic b_txn(input logic we, input logic [31:0] addr, input logic [255:0] wdata,
                         output logic [255:0] rdata, output int lat);
        int n;
        b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        b_req_valid = 1'b1; b_resp_ready = 1'b1;
        n = 0;
        while (!b_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (b_req_ready !== 1'b1) begin
            errors++; $display("FAIL b_accept: req_ready=%b required 1", b_req_ready);
        end
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        lat = 0;
        while (!b_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = b_resp_rdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", a_req_ready); end
        checks++;
        if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b required 0", a_resp_valid); end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", a_busy); end
        checks++;
        if (a_resp_rdata !== 128'h0) begin errors++; $display("FAIL rst_rdata: got %h required 0", a_resp_rdata); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_a: got %b required 1", a_req_ready); end
        checks++;
        if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_b: got %b required 1", b_req_ready); end
    endtask

    task automatic test_write_read();
        logic [127:0] rd;
        int lat;
        a_txn(1'b1, 32'h40, L1, rd, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL wr_latency: got %0d required 9", lat); end
        checks++;
        if (rd !== L1) begin errors++; $display("FAIL wr_echo: got %h required %h", rd, L1); end
        a_txn(1'b0, 32'h4C, 128'h0, rd, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL rd_latency: got %0d required 9", lat); end
        checks++;
        if (rd !== L1) begin errors++; $display("FAIL rd_data: got %h required %h", rd, L1); end
    endtask

    task automatic test_backpressure();
        logic [127:0] snap;
        int lat;
        a_req_we = 1'b0; a_req_addr = 32'h40; a_req_wdata = '0;
        a_req_valid = 1'b1; a_resp_ready = 1'b0;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 0;
        while (!a_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL bp_latency: got %0d required 9", lat); end
        snap = a_resp_rdata;
        checks++;
        if (snap !== L1) begin errors++; $display("FAIL bp_data: got %h required %h", snap, L1); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (a_resp_valid !== 1'b1 || a_resp_rdata !== snap || a_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h required 1/0/%h",
                         i, a_resp_valid, a_req_ready, a_resp_rdata, snap);
            end
        end
        // Present the next request while the response is still pending.
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h4C; a_resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_resp_valid !== 1'b0 || a_busy !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle: valid=%b busy=%b ready=%b required 0/0/1",
                     a_resp_valid, a_busy, a_req_ready);
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: busy=%b required 1", a_busy); end
        lat = 0;
        while (!a_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 9 || a_resp_rdata !== L1) begin
            errors++; $display("FAIL bp_next_resp: lat=%0d data=%h required 9/%h", lat, a_resp_rdata, L1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [127:0] rd;
        int lat;
        a_txn(1'b1, 32'h1000, LA, rd, lat);
        checks++;
        if (lat !== 9 || rd !== LA) begin
            errors++; $display("FAIL wrap_wr: lat=%0d data=%h required 9/%h", lat, rd, LA);
        end
        a_txn(1'b0, 32'h0, 128'h0, rd, lat);
        checks++;
        if (rd !== LA) begin errors++; $display("FAIL wrap_rd: got %h required %h", rd, LA); end
    endtask

    task automatic test_reset_mid_write();
        logic [127:0] rd;
        logic         seen;
        int lat;
        a_txn(1'b1, 32'h80, 128'h0, rd, lat);
        a_req_we = 1'b1; a_req_addr = 32'h80; a_req_wdata = LB;
        a_req_valid = 1'b1; a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        // Four WAIT edges then the beat-0 write edge; reset hits the beat-1 edge.
        repeat (5) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (a_busy !== 1'b0 || a_resp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_state: busy=%b valid=%b required 0/0", a_busy, a_resp_valid);
        end
        seen = 1'b0;
        repeat (15) begin @(posedge clk); #1; if (a_resp_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_noresp: resp seen=%b required 0", seen); end
        a_txn(1'b0, 32'h80, 128'h0, rd, lat);
        checks++;
        if (rd !== {96'h0, 32'hB0}) begin
            errors++; $display("FAIL mid_rst_ram: got %h required %h", rd, {96'h0, 32'hB0});
        end
    endtask

    task automatic test_param_sweep();
        logic [255:0] wd, rd;
        int lat;
        for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'hC0C00000 + i;
        b_txn(1'b1, 32'h100, wd, rd, lat);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL sweep_wr_latency: got %0d required 10", lat); end
        checks++;
        if (rd !== wd) begin errors++; $display("FAIL sweep_echo: got %h required %h", rd, wd); end
        b_txn(1'b0, 32'h11C, 256'h0, rd, lat);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL sweep_rd_latency: got %0d required 10", lat); end
        checks++;
        if (rd !== wd) begin errors++; $display("FAIL sweep_rd_data: got %h required %h", rd, wd); end
    endtask

    initial begin
        rst = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_wrap();
        test_reset_mid_write();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
